// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between two writeback requesters.
// Per-requester FIFOs feed a round-robin arbiter and a one-cycle registered write stage.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic [ADDR_W-1:0]        rf_writeReg,
    output logic [DATA_W-1:0]        rf_writeData,
    output logic                     rf_RegWrite,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_addr [2][DEPTH];
    logic [DATA_W-1:0] mem_data [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [2];
    logic [PTR_W-1:0]  wr_ptr   [2];
    logic [CNT_W-1:0]  count    [2];

    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_data  [2];
    logic [1:0]        in_valid;
    logic [1:0]        not_full;
    logic [1:0]        not_empty;
    logic [1:0]        push;
    logic [1:0]        pop;

    logic              grant_valid;
    logic              grant_sel;
    logic              last_grant;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
    always_comb begin
        in_valid   = {req1_valid, req0_valid};
        in_addr[0] = req0_addr;
        in_addr[1] = req1_addr;
        in_data[0] = req0_data;
        in_data[1] = req1_data;
        for (int n = 0; n < 2; n++) begin
            not_full[n]  = (count[n] != CNT_W'(DEPTH));
            not_empty[n] = (count[n] != '0);
            push[n]      = in_valid[n] & not_full[n];
        end
    end

    assign req0_ready = not_full[0];
    assign req1_ready = not_full[1];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = |not_empty;
        grant_sel   = 1'b0;
        pop         = '0;
        if (&not_empty) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = not_empty[1];
        end
        if (grant_valid) begin
            pop[grant_sel] = 1'b1;
        end
        head_addr = mem_addr[grant_sel][rd_ptr[grant_sel]];
        head_data = mem_data[grant_sel][rd_ptr[grant_sel]];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr[n] <= '0;
                wr_ptr[n] <= '0;
                count[n]  <= '0;
            end
            last_grant <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
                end
                count[n] <= count[n] + CNT_W'(push[n]) - CNT_W'(pop[n]);
            end
            if (grant_valid) begin
                last_grant <= grant_sel;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_addr[n][wr_ptr[n]] <= in_addr[n];
                mem_data[n][wr_ptr[n]] <= in_data[n];
            end
        end
    end

    // Writes to register 0 are consumed but never presented to the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_RegWrite  <= 1'b0;
            rf_writeReg  <= '0;
            rf_writeData <= '0;
        end else begin
            rf_RegWrite <= grant_valid && (head_addr != '0);
            if (grant_valid && (head_addr != '0)) begin
                rf_writeReg  <= head_addr;
                rf_writeData <= head_data;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pending = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [PTR_W-1:0] off;
                off = PTR_W'(i) - rd_ptr[n];
                if (CNT_W'(off) < count[n]) begin
                    pending[mem_addr[n][i]] = 1'b1;
                end
            end
        end
        if (rf_RegWrite) begin
            pending[rf_writeReg] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign busy = (|not_empty) | rf_RegWrite;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the arbiter's rules.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic [ADDR_W-1:0] rf_writeReg;
    logic [DATA_W-1:0] rf_writeData;
    logic              rf_RegWrite;
    logic [31:0]       pending;
    logic              busy;

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .rf_RegWrite  (rf_RegWrite),
        .pending      (pending),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared   = 0;
    int mismatched = 0;

    // Reference model: two queues, a "last granted" bit and the staged write.
    ent_t              q0[$];
    ent_t              q1[$];
    bit                m_last;
    bit                m_we;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;
    int                wr_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (q0[i]) p[q0[i].addr] = 1'b1;
        foreach (q1[i]) p[q1[i].addr] = 1'b1;
        if (m_we) p[m_reg] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One rising edge of the model, using the pre-edge queue contents.
    task automatic model_step(input bit acc0, input ent_t e0, input bit acc1, input ent_t e1);
        bit   g;
        ent_t h;
        if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) g = ~m_last;
            else                                g = (q0.size() == 0);
            h      = g ? q1.pop_front() : q0.pop_front();
            m_last = g;
            if (h.addr != 0) begin
                m_we   = 1'b1;
                m_reg  = h.addr;
                m_data = h.data;
            end else begin
                m_we = 1'b0;
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc0) q0.push_back(e0);
        if (acc1) q1.push_back(e1);
    endtask

    task automatic check_outputs();
        check("req0_ready", req0_ready, q0.size() != DEPTH);
        check("req1_ready", req1_ready, q1.size() != DEPTH);
        check("rf_RegWrite", rf_RegWrite, m_we);
        check("rf_writeReg", rf_writeReg, m_reg);
        check("rf_writeData", rf_writeData, m_data);
        check("pending", pending, model_pending());
        check("busy", busy, (q0.size() != 0) || (q1.size() != 0) || m_we);
        if (rf_RegWrite) wr_log.push_back(int'(rf_writeReg));
    endtask

    // Drive one cycle from a negedge, step the model at the posedge, check at the next negedge.
    task automatic cycle(input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         output bit acc0, output bit acc1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        acc0 = v0 && (q0.size() != DEPTH);
        acc1 = v1 && (q1.size() != DEPTH);
        @(posedge clk);
        model_step(acc0, '{addr: a0, data: d0}, acc1, '{addr: a1, data: d1});
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a0, a1);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        bit acc0, acc1;
        int idx0, idx1, n1, guard;
        int exp_order[6];
        logic [ADDR_W-1:0] c_addr0[3];
        logic [ADDR_W-1:0] c_addr1[3];

        reset = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        model_reset();

        // Reset held for two cycles, then idle.
        @(negedge clk);
        @(negedge clk);
        check("rst_RegWrite", rf_RegWrite, 1'b0);
        check("rst_writeReg", rf_writeReg, '0);
        check("rst_writeData", rf_writeData, '0);
        check("rst_pending", pending, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        #1;
        check("rel_ready0", req0_ready, 1'b1);
        check("rel_ready1", req1_ready, 1'b1);
        idle(2);

        // Single write to register 5.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, acc0, acc1);
        check("single_acc", acc0, 1'b1);
        check("single_pend_N", pending[5], 1'b1);
        idle(1);
        check("single_we", rf_RegWrite, 1'b1);
        check("single_reg", rf_writeReg, 5'd5);
        check("single_data", rf_writeData, 32'hDEAD_BEEF);
        idle(1);
        check("single_we_off", rf_RegWrite, 1'b0);
        check("single_pend_clr", pending[5], 1'b0);
        check("single_busy", busy, 1'b0);

        // Contention from a fresh reset: expect strict alternation starting with req0.
        apply_reset();
        wr_log.delete();
        c_addr0 = '{5'd1, 5'd2, 5'd3};
        c_addr1 = '{5'd11, 5'd12, 5'd13};
        exp_order = '{1, 11, 2, 12, 3, 13};
        idx0 = 0; idx1 = 0; guard = 0;
        while ((idx0 < 3 || idx1 < 3) && guard < 20) begin
            cycle(idx0 < 3, (idx0 < 3) ? c_addr0[idx0] : 5'd0, 32'h100 + 32'(idx0),
                  idx1 < 3, (idx1 < 3) ? c_addr1[idx1] : 5'd0, 32'h200 + 32'(idx1), acc0, acc1);
            if (acc0) idx0++;
            if (acc1) idx1++;
            guard++;
        end
        check("cont_accepts", 64'(idx0 + idx1), 64'd6);
        idle(6);
        check("cont_count", 64'(wr_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_log.size()) check($sformatf("cont_order%0d", i), 64'(wr_log[i]), 64'(exp_order[i]));
        end

        // Full FIFO1: req0 wins the first arbitration, so FIFO1 fills after two accepts.
        apply_reset();
        idx0 = 0; n1 = 0;
        for (int i = 0; i < 8 && n1 < 4; i++) begin
            cycle(idx0 < 3, 5'd20 + 5'(idx0), 32'hA000 + 32'(idx0),
                  1'b1, 5'd24 + 5'(n1), 32'hB000 + 32'(n1), acc0, acc1);
            if (acc0) idx0++;
            if (acc1) begin
                n1++;
                if (n1 == 2) check("full_ready1", req1_ready, 1'b0);
            end
        end
        check("full_accepts", 64'(n1), 64'd4);
        idle(8);

        // Register 0 write: handshake completes, nothing reaches the register file.
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, acc0, acc1);
        check("r0_acc", acc1, 1'b1);
        check("r0_pend", pending, '0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("r0_we", rf_RegWrite, 1'b0);
            check("r0_pend_hold", pending, '0);
        end

        // Reset asserted while entries are queued and a write is staged.
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, acc0, acc1);
        cycle(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, acc0, acc1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_we", rf_RegWrite, 1'b0);
        check("mid_rst_pend", pending, '0);
        check("mid_rst_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        wr_log.delete();
        idle(4);
        check("mid_rst_nowrite", 64'(wr_log.size()), 64'd0);

        // Random traffic, including register 0 and back-to-back contention.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom, acc0, acc1);
        end
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_we) && guard < 20) begin
            idle(1);
            guard++;
        end
        check("drain_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (writeReg/writeData/RegWrite) between two writeback requesters, e.g. ALU writeback (req0) and load writeback (req1).
- Each requester has a small FIFO with a valid/ready handshake. Non-empty FIFOs are drained through a round-robin arbiter into a registered write stage that drives the register file.
- Exports a pending-write bitmap so issue/stall logic can detect outstanding writes per register.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (32 registers)
DEPTH, 2, entries per requester FIFO; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req0_valid  input  1  requester 0 has a write
req0_ready  output  1  requester 0 FIFO can accept
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req1_valid  input  1  requester 1 has a write
req1_ready  output  1  requester 1 FIFO can accept
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
rf_writeReg  output  ADDR_W  to register file writeReg
rf_writeData  output  DATA_W  to register file writeData
rf_RegWrite  output  1  to register file RegWrite
pending  output  2^ADDR_W  bit i = 1 while any queued or staged write targets register i
busy  output  1  any FIFO non-empty or write stage valid

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous, active-low.
- Reset (reset=0, any time, including mid-operation):
  - Both FIFOs flushed (counts 0, pointers 0); queued writes are discarded.
  - rf_RegWrite=0, rf_writeReg=0, rf_writeData=0.
  - pending=0, busy=0.
  - Round-robin pointer favours req0.
  - req0_ready=req1_ready=1 once reset deasserts.
- Acceptance:
  - A transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1. addr/data are pushed into FIFO N.
  - reqN_ready = (registered count_N != DEPTH). It does not depend combinationally on valid, or on a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
  - Push and pop in the same cycle on a non-full FIFO: count is unchanged, order is preserved.
  - FIFO pointers wrap modulo DEPTH.
- Arbitration (combinational from FIFO heads, each cycle):
  - Only FIFO0 non-empty: grant 0. Only FIFO1 non-empty: grant 1. Neither: no grant.
  - Both non-empty: grant the requester not granted last. The pointer updates only on a grant.
  - The granted head is popped at the next rising edge.
- Write stage (registered):
  - On a grant with head addr != 0: at the next edge load rf_writeReg/rf_writeData from the head and set rf_RegWrite=1 for exactly one cycle.
  - Head addr == 0: entry is popped, rf_RegWrite=0, rf_writeReg/rf_writeData hold. Register 0 is never written.
  - No grant: rf_RegWrite=0, data/address hold previous values.
- Throughput and latency:
  - Throughput is one write per cycle total.
  - A write accepted at edge N into an empty FIFO with no contention has rf_RegWrite=1 during cycle N+1 to N+2. The register file commits it at edge N+2.
- Ordering:
  - Per requester: strict FIFO.
  - Across requesters: arbitration order. Same address from both requesters is not merged; the later-granted write wins in the register file.
- pending:
  - OR over all valid FIFO entries and the write stage (when rf_RegWrite=1) of one-hot(addr).
  - Bit 0 is always 0.
  - A bit clears in the cycle after its last staged write.
- busy = (count_0 != 0) | (count_1 != 0) | rf_RegWrite.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → all outputs 0. After release: req0_ready=req1_ready=1, busy=0, pending=0.
- Single write: req0 addr=5, data=0xDEADBEEF accepted at edge N → pending[5]=1 from cycle N. rf_RegWrite=1, rf_writeReg=5, rf_writeData=0xDEADBEEF during cycle N+1 only. pending[5]=0 and busy=0 from edge N+2.
- Contention: both requesters push 3 writes each every cycle (req0 addr 1,2,3; req1 addr 11,12,13) → staged order 1,11,2,12,3,13. Ready drops once a FIFO holds DEPTH entries. No entry lost or duplicated.
- Full FIFO: hold the other FIFO busy so FIFO1 is starved while req1_valid=1 for 4 cycles → req1_ready=0 after 2 accepts. Third item accepted only after the first pop. req1_data sequence is preserved.
- Register 0: req1 addr=0, data=0x1234 → handshake completes, rf_RegWrite stays 0, pending=0.
- Reset mid-operation: 3 entries queued, assert reset → same cycle (async) rf_RegWrite=0, pending=0, busy=0. No write issues after release.
